// File: rtl/cuckoo_lookup.sv
// Read-side lookup engine for the two-table cuckoo hash.
// Probes arr1 at h1, then arr2 at h2, one lookup in flight.
module cuckoo_lookup #(
  parameter int KEY_W  = 32,
  parameter int DEPTH  = 10,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [KEY_W-1:0]  req_key,
  output logic              t1_rd_en,
  output logic [IDX_W-1:0]  t1_rd_addr,
  input  logic [KEY_W-1:0]  t1_rd_data,
  input  logic              t1_rd_vld,
  output logic              t2_rd_en,
  output logic [IDX_W-1:0]  t2_rd_addr,
  input  logic [KEY_W-1:0]  t2_rd_data,
  input  logic              t2_rd_vld,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_table,
  output logic [IDX_W-1:0]  rsp_index,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_CMP1,
    S_RD2,
    S_CMP2,
    S_RESP
  } state_t;

  localparam logic [KEY_W-1:0] DEP_K =
    KEY_W'(DEPTH);
  localparam logic [KEY_W+1:0] DEP_W =
    (KEY_W+2)'(DEPTH);
  localparam logic [KEY_W+1:0] THREE =
    (KEY_W+2)'(3);

  state_t state_q, state_d;

  logic [KEY_W-1:0]  key_q;
  logic [IDX_W-1:0]  h2_q;
  logic [IDX_W-1:0]  t1_addr_q;
  logic [IDX_W-1:0]  t2_addr_q;
  logic              hit_q;
  logic              tbl_q;
  logic [IDX_W-1:0]  idx_q;
  logic [STAT_W-1:0] hit_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;

  logic [KEY_W+1:0]  key3;
  logic [IDX_W-1:0]  h1_w;
  logic [IDX_W-1:0]  h2_w;
  logic              accept;
  logic              rsp_fire;
  logic              t1_match;
  logic              t2_match;

  // key*3 is widened so the top bits survive
  assign key3  = {2'b00, req_key} * THREE;
  assign h1_w  = IDX_W'(req_key % DEP_K);
  assign h2_w  = IDX_W'(key3 % DEP_W);

  assign accept   = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // stale slots (vld=0) never match
  assign t1_match = t1_rd_vld &&
                    (t1_rd_data == key_q);
  assign t2_match = t2_rd_vld &&
                    (t2_rd_data == key_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; table 1 hit skips table 2
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RD1;
      S_RD1:  state_d = S_CMP1;
      S_CMP1: state_d = t1_match ? S_RESP
                                 : S_RD2;
      S_RD2:  state_d = S_CMP2;
      S_CMP2: state_d = S_RESP;
      S_RESP: if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // handshake and strobe outputs decoded from state
  always_comb begin
    req_ready = 1'b0;
    t1_rd_en  = 1'b0;
    t2_rd_en  = 1'b0;
    rsp_valid = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): req_ready = rst_n;
      (state_q == S_RD1):  t1_rd_en  = 1'b1;
      (state_q == S_RD2):  t2_rd_en  = 1'b1;
      (state_q == S_RESP): rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // key/hash capture, read addresses and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      h2_q      <= '0;
      t1_addr_q <= '0;
      t2_addr_q <= '0;
      hit_q     <= 1'b0;
      tbl_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (accept) begin
        key_q     <= req_key;
        t1_addr_q <= h1_w;
        h2_q      <= h2_w;
      end
      if (state_q == S_CMP1) begin
        if (t1_match) begin
          hit_q <= 1'b1;
          tbl_q <= 1'b0;
          idx_q <= t1_addr_q;
        end else begin
          t2_addr_q <= h2_q;
        end
      end
      if (state_q == S_CMP2) begin
        hit_q <= t2_match;
        tbl_q <= t2_match;
        idx_q <= t2_match ? t2_addr_q
                          : '0;
      end
    end
  end

  // saturating statistics, one step per response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rsp_fire) begin
      if (hit_q) begin
        if (hit_cnt_q != '1)
          hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1)
          miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign t1_rd_addr = t1_addr_q;
  assign t2_rd_addr = t2_addr_q;
  assign rsp_hit    = hit_q;
  assign rsp_table  = tbl_q;
  assign rsp_index  = idx_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Bench for cuckoo_lookup: table RAM model,
// per-cycle reference model and directed lookups.
module tb_cuckoo_lookup;

  localparam int KW = 32;
  localparam int DP = 10;
  localparam int IW = 4;
  localparam int SW = 3;
  localparam int SMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [KW-1:0] req_key = '0;
  logic          t1_rd_en, t2_rd_en;
  logic [IW-1:0] t1_rd_addr, t2_rd_addr;
  logic [KW-1:0] t1_rd_data = '0;
  logic [KW-1:0] t2_rd_data = '0;
  logic          t1_rd_vld = 1'b0;
  logic          t2_rd_vld = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_hit, rsp_table;
  logic [IW-1:0] rsp_index;
  logic [SW-1:0] hit_count, miss_count;

  cuckoo_lookup #(
    .KEY_W(KW), .DEPTH(DP),
    .IDX_W(IW), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_key(req_key),
    .t1_rd_en(t1_rd_en),
    .t1_rd_addr(t1_rd_addr),
    .t1_rd_data(t1_rd_data),
    .t1_rd_vld(t1_rd_vld),
    .t2_rd_en(t2_rd_en),
    .t2_rd_addr(t2_rd_addr),
    .t2_rd_data(t2_rd_data),
    .t2_rd_vld(t2_rd_vld),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit),
    .rsp_table(rsp_table),
    .rsp_index(rsp_index),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // shared tables, 1-cycle sync read
  logic [KW-1:0] arr1 [DP];
  logic [KW-1:0] arr2 [DP];
  bit            ch1  [DP];
  bit            ch2  [DP];

  always @(posedge clk) begin
    if (t1_rd_en) begin
      t1_rd_data <= arr1[t1_rd_addr];
      t1_rd_vld  <= ch1[t1_rd_addr];
    end
    if (t2_rd_en) begin
      t2_rd_data <= arr2[t2_rd_addr];
      t2_rd_vld  <= ch2[t2_rd_addr];
    end
  end

  task automatic clear_tables();
    for (int i = 0; i < DP; i++) begin
      arr1[i] = '0; arr2[i] = '0;
      ch1[i] = 0;   ch2[i] = 0;
    end
  endtask

  // reference model: result and timing from the rules
  bit     busy;
  int     age;
  int     elat;
  bit     e1hit, ehit, etbl;
  int     eidx, eh1, eh2;
  int     mhit, mmiss;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; age = 0;
      mhit = 0; mmiss = 0;
    end else if (busy) begin
      if (age >= elat && rsp_ready) begin
        busy = 0;
        if (ehit) begin
          if (mhit < SMAX) mhit++;
        end else begin
          if (mmiss < SMAX) mmiss++;
        end
      end else begin
        age++;
      end
    end else if (req_valid) begin
      busy = 1;
      age  = 1;
      eh1  = int'(longint'(req_key) % DP);
      eh2  = int'((longint'(req_key) * 3) % DP);
      e1hit = ch1[eh1] && arr1[eh1] == req_key;
      if (e1hit) begin
        ehit = 1; etbl = 0;
        eidx = eh1; elat = 3;
      end else if (ch2[eh2] &&
                   arr2[eh2] == req_key) begin
        ehit = 1; etbl = 1;
        eidx = eh2; elat = 5;
      end else begin
        ehit = 0; etbl = 0;
        eidx = 0; elat = 5;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    bit ev;
    ev = busy && age >= elat;
    chk("req_ready", req_ready,
        rst_n && !busy);
    chk("rsp_valid", rsp_valid, ev);
    chk("t1_rd_en", t1_rd_en,
        busy && age == 1);
    chk("t2_rd_en", t2_rd_en,
        busy && age == 3 && !e1hit);
    if (busy && age == 1)
      chk("t1_rd_addr", t1_rd_addr, eh1);
    if (busy && age == 3 && !e1hit)
      chk("t2_rd_addr", t2_rd_addr, eh2);
    if (ev) begin
      chk("rsp_hit", rsp_hit, ehit);
      chk("rsp_table", rsp_table, etbl);
      chk("rsp_index", rsp_index, eidx);
    end
    chk("hit_count", hit_count, mhit);
    chk("miss_count", miss_count, mmiss);
  end

  // one lookup; stall = cycles rsp_ready is held low
  task automatic lookup(input  logic [KW-1:0] k,
                        input  int stall,
                        output int h, output int t,
                        output int ix, output int lat,
                        output int a1, output int a2,
                        output int hc_pre);
    @(negedge clk);
    req_valid = 1'b1;
    req_key   = k;
    rsp_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_key   = ~k;
    lat = 1; a1 = -1; a2 = -1;
    while (1) begin
      if (t1_rd_en) a1 = t1_rd_addr;
      if (t2_rd_en) a2 = t2_rd_addr;
      if (rsp_valid || lat >= 20) break;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid)
      chk("rsp_timeout", 0, 1);
    h = rsp_hit; t = rsp_table;
    ix = rsp_index;
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      hc_pre = hit_count;
      rsp_ready = 1'b1;
      @(negedge clk);
    end else begin
      hc_pre = hit_count;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  int h, t, ix, lat, a1, a2, hp;

  initial begin
    clear_tables();
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_addr", t1_rd_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    // table-1 hit
    arr1[2] = 42; ch1[2] = 1;
    lookup(42, 0, h, t, ix, lat, a1, a2, hp);
    chk("t1_addr", a1, 2);
    chk("t1_lat", lat, 3);
    chk("t1_hit", h, 1);
    chk("t1_tbl", t, 0);
    chk("t1_idx", ix, 2);
    chk("t1_hc", hit_count, 1);

    // table-2 hit
    arr1[2] = 7; arr2[6] = 42; ch2[6] = 1;
    lookup(42, 0, h, t, ix, lat, a1, a2, hp);
    chk("t2_addr", a2, 6);
    chk("t2_lat", lat, 5);
    chk("t2_hit", h, 1);
    chk("t2_tbl", t, 1);
    chk("t2_idx", ix, 6);
    chk("t2_hc", hit_count, 2);

    // stale data in both tables is a miss
    clear_tables();
    arr1[2] = 42; arr2[6] = 42;
    lookup(42, 0, h, t, ix, lat, a1, a2, hp);
    chk("miss_lat", lat, 5);
    chk("miss_hit", h, 0);
    chk("miss_tbl", t, 0);
    chk("miss_idx", ix, 0);
    chk("miss_mc", miss_count, 1);

    // full-width key, no truncation of key*3
    lookup(32'hFFFF_FFFF, 0,
           h, t, ix, lat, a1, a2, hp);
    chk("wide_a1", a1, 5);
    chk("wide_a2", a2, 5);
    chk("wide_mc", miss_count, 2);

    // backpressure on a table-1 hit
    arr1[2] = 42; ch1[2] = 1;
    lookup(42, 4, h, t, ix, lat, a1, a2, hp);
    chk("bp_hc_pre", hp, 2);
    chk("bp_hc_post", hit_count, 3);

    // present in both tables: table 1 wins
    ch2[6] = 1;
    lookup(42, 0, h, t, ix, lat, a1, a2, hp);
    chk("prio_tbl", t, 0);
    chk("prio_idx", ix, 2);
    chk("prio_lat", lat, 3);

    // saturation of the hit counter
    for (int i = 0; i < 4; i++)
      lookup(42, 0, h, t, ix, lat, a1, a2, hp);
    chk("sat_hc", hit_count, SMAX);
    chk("sat_mc", miss_count, 2);

    // reset while in RD2
    clear_tables();
    @(negedge clk);
    req_valid = 1'b1;
    req_key   = 42;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd2_reached", t2_rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_rsp_hit", rsp_hit, 0);
    chk("ar_rsp_table", rsp_table, 0);
    chk("ar_rsp_index", rsp_index, 0);
    chk("ar_t1_en", t1_rd_en, 0);
    chk("ar_t2_en", t2_rd_en, 0);
    chk("ar_t1_addr", t1_rd_addr, 0);
    chk("ar_t2_addr", t2_rd_addr, 0);
    chk("ar_hc", hit_count, 0);
    chk("ar_mc", miss_count, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    arr1[2] = 42; ch1[2] = 1;
    lookup(42, 0, h, t, ix, lat, a1, a2, hp);
    chk("post_rst_hit", h, 1);
    chk("post_rst_hc", hit_count, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
